// File: rtl/out_port.sv
// Credit-based transmit side of a router link: per-VC credit counters, round-robin VC arbiter, registered flit output.
// Optional sticky credit-overflow flag enabled by defining OUT_PORT_CREDIT_CHK_EN.
`ifndef FLIT_SIZE
`define FLIT_SIZE 32
`endif
`ifndef FLIT_VC
`define FLIT_VC 2:0
`endif

module out_port #(
  parameter int VC_NUM    = 4,
  parameter int BUF_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [VC_NUM-1:0]             vc_req,
  input  logic [VC_NUM*`FLIT_SIZE-1:0]  vc_flit,
  input  logic [VC_NUM-1:0]             credit_in,
  output logic [VC_NUM-1:0]             vc_grant,
  output logic [`FLIT_SIZE-1:0]         flit_out,
  output logic                          valid_out
`ifdef OUT_PORT_CREDIT_CHK_EN
  ,
  output logic                          credit_err
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic [CNT_W-1:0]      cnt_r [VC_NUM];
  logic [PTR_W-1:0]      rr_ptr_r;
  logic [VC_NUM-1:0]     nz_s;
  logic [VC_NUM-1:0]     full_s;
  logic [VC_NUM-1:0]     elig_s;
  logic [VC_NUM-1:0]     grant_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic                  grant_vld_s;
  logic [PTR_W:0]        sum_s;
  logic [PTR_W-1:0]      idx_s;
  logic [PTR_W-1:0]      next_ptr_s;
  logic [`FLIT_SIZE-1:0] sel_flit_s;

  // Per-VC credit status; a credit arriving this cycle never makes an empty VC eligible.
  always_comb begin
    nz_s   = '0;
    full_s = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      nz_s[v]   = (cnt_r[v] != '0);
      full_s[v] = (cnt_r[v] == CNT_W'(BUF_DEPTH));
    end
    elig_s = vc_req & nz_s & {VC_NUM{~reset}};
  end

  // Round-robin search starting at rr_ptr_r, wrapping at VC_NUM-1.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    grant_vld_s = 1'b0;
    sum_s       = '0;
    idx_s       = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
      if (sum_s >= (PTR_W+1)'(VC_NUM)) sum_s = sum_s - (PTR_W+1)'(VC_NUM);
      else                             sum_s = sum_s;
      idx_s = sum_s[PTR_W-1:0];
      if (!grant_vld_s && elig_s[idx_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (grant_vld_s) grant_s[grant_idx_s] = 1'b1;
    else             grant_s = '0;
  end

  assign vc_grant = grant_s;

  // Granted flit with its VC field rewritten to the granted VC id.
  always_comb begin
    sel_flit_s = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (grant_s[v]) sel_flit_s = vc_flit[v*`FLIT_SIZE +: `FLIT_SIZE];
      else            sel_flit_s = sel_flit_s;
    end
    sel_flit_s[`FLIT_VC] = 3'(grant_idx_s);
  end

  // Pointer moves just past the VC that won.
  always_comb begin
    next_ptr_s = rr_ptr_r;
    if (grant_idx_s == PTR_W'(VC_NUM - 1)) next_ptr_s = '0;
    else                                   next_ptr_s = grant_idx_s + PTR_W'(1);
  end

  // Output register and arbitration pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      flit_out  <= '0;
      rr_ptr_r  <= '0;
    end else if (grant_vld_s) begin
      valid_out <= 1'b1;
      flit_out  <= sel_flit_s;
      rr_ptr_r  <= next_ptr_s;
    end else begin
      valid_out <= 1'b0;
      flit_out  <= flit_out;
      rr_ptr_r  <= rr_ptr_r;
    end
  end

  // Credit counters: send and credit in the same cycle cancel; overflow credits are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VC_NUM; v++) cnt_r[v] <= CNT_W'(BUF_DEPTH);
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        case ({grant_s[v], credit_in[v]})
          2'b10:   cnt_r[v] <= cnt_r[v] - CNT_W'(1);
          2'b01: begin
            if (!full_s[v]) cnt_r[v] <= cnt_r[v] + CNT_W'(1);
            else            cnt_r[v] <= cnt_r[v];
          end
          default: cnt_r[v] <= cnt_r[v];
        endcase
      end
    end
  end

`ifdef OUT_PORT_CREDIT_CHK_EN
  logic overflow_s;
  assign overflow_s = |(credit_in & ~grant_s & full_s);

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           credit_err <= 1'b0;
    else if (overflow_s) credit_err <= 1'b1;
    else                 credit_err <= credit_err;
  end
`endif

endmodule

// File: tb/tb_out_port.sv
// Scoreboard bench for out_port: a queue-based reference model predicts grants, flits, latency and credit state.
`ifndef FLIT_SIZE
`define FLIT_SIZE 32
`endif
`ifndef FLIT_VC
`define FLIT_VC 2:0
`endif

module tb_out_port;
  localparam int VC_NUM    = 4;
  localparam int BUF_DEPTH = 4;
  localparam int FW        = `FLIT_SIZE;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [VC_NUM-1:0]       vc_req;
  logic [VC_NUM*FW-1:0]    vc_flit;
  logic [VC_NUM-1:0]       credit_in;
  logic [VC_NUM-1:0]       vc_grant;
  logic [FW-1:0]           flit_out;
  logic                    valid_out;
`ifdef OUT_PORT_CREDIT_CHK_EN
  logic                    credit_err;
`endif

  out_port #(.VC_NUM(VC_NUM), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clock(clock), .reset(reset), .vc_req(vc_req), .vc_flit(vc_flit),
    .credit_in(credit_in), .vc_grant(vc_grant), .flit_out(flit_out),
    .valid_out(valid_out)
`ifdef OUT_PORT_CREDIT_CHK_EN
    , .credit_err(credit_err)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [FW-1:0] flit; int due; } exp_t;
  exp_t          sb_q[$];
  int            m_cnt[VC_NUM];
  int            m_ptr;
  bit            m_err;
  logic [FW-1:0] src_flit[VC_NUM];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < VC_NUM; v++) m_cnt[v] = BUF_DEPTH;
    m_ptr = 0;
    m_err = 1'b0;
    sb_q.delete();
  endfunction

  function automatic int model_pick(input logic [VC_NUM-1:0] req);
    for (int k = 0; k < VC_NUM; k++) begin
      int v = (m_ptr + k) % VC_NUM;
      if (req[v] && m_cnt[v] > 0) return v;
    end
    return -1;
  endfunction

  function automatic logic [VC_NUM-1:0] owed_mask();
    logic [VC_NUM-1:0] m = '0;
    for (int v = 0; v < VC_NUM; v++) m[v] = (m_cnt[v] < BUF_DEPTH);
    return m;
  endfunction

  // One cycle: drive, check grant against the model, queue the expected flit, advance the model.
  task automatic step(input logic [VC_NUM-1:0] req, input logic [VC_NUM-1:0] cr, output int g);
    logic [FW-1:0] f;
    @(negedge clock);
    vc_req    = req;
    credit_in = cr;
    for (int v = 0; v < VC_NUM; v++) vc_flit[v*FW +: FW] = src_flit[v];
    #1;
    g = model_pick(req);
    check("vc_grant", 64'(vc_grant), (g < 0) ? 64'd0 : (64'd1 << g));
`ifdef OUT_PORT_CREDIT_CHK_EN
    check("credit_err", 64'(credit_err), 64'(m_err));
`endif
    if (g >= 0) begin
      f = src_flit[g];
      f[`FLIT_VC] = 3'(g);
      sb_q.push_back('{f, cyc + 1});
      m_ptr = (g + 1) % VC_NUM;
    end
    for (int v = 0; v < VC_NUM; v++) begin
      int s = (g == v) ? 1 : 0;
      int c = cr[v] ? 1 : 0;
      if (c == 1 && s == 0 && m_cnt[v] == BUF_DEPTH) m_err = 1'b1;
      else m_cnt[v] = m_cnt[v] + c - s;
    end
  endtask

  task automatic refill();
    int g;
    for (int n = 0; n < BUF_DEPTH + 1; n++) step('0, owed_mask(), g);
  endtask

  // Asserted between edges so the async clear is observed without a clock.
  task automatic do_reset();
    @(negedge clock);
    vc_req    = '1;
    credit_in = '0;
    check("sb_drained_before_reset", 64'(sb_q.size()), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("reset_valid_out", 64'(valid_out), 64'd0);
    check("reset_vc_grant", 64'(vc_grant), 64'd0);
    model_reset();
    @(negedge clock);
    check("reset_flit_out", 64'(flit_out), 64'd0);
`ifdef OUT_PORT_CREDIT_CHK_EN
    check("reset_credit_err", 64'(credit_err), 64'd0);
`endif
    vc_req = '0;
    reset  = 1'b0;
  endtask

  // Monitor: every valid flit must match the head of the scoreboard, in the predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && valid_out) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_flit: got %0h expected no flit (cyc=%0d)", flit_out, cyc);
        end else begin
          e = sb_q.pop_front();
          check("flit_out", 64'(flit_out), 64'(e.flit));
          check("flit_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    int g;
    logic [VC_NUM-1:0] rq;
    logic [VC_NUM-1:0] cr;
    reset     = 1'b1;
    vc_req    = '1;
    credit_in = '0;
    vc_flit   = '0;
    for (int v = 0; v < VC_NUM; v++) src_flit[v] = $urandom;
    model_reset();
    #1;
    check("init_valid_out", 64'(valid_out), 64'd0);
    check("init_flit_out", 64'(flit_out), 64'd0);
    check("init_vc_grant", 64'(vc_grant), 64'd0);
    @(negedge clock);
    vc_req = '0;
    @(negedge clock);
    reset = 1'b0;

    // Single VC drains its credits, stalls, then one credit allows exactly one more flit.
    src_flit[2] = $urandom;
    for (int n = 0; n < 7; n++) step(4'b0100, 4'b0000, g);
    step(4'b0100, 4'b0100, g);
    for (int n = 0; n < 3; n++) step(4'b0100, 4'b0000, g);
    refill();

    // All VCs requesting with credits returned every cycle.
    for (int n = 0; n < 6; n++) step(4'b1111, owed_mask(), g);
    refill();

    // Send and credit on the same VC in the same cycle.
    for (int n = 0; n < 3; n++) step(4'b0010, 4'b0000, g);
    step(4'b0010, 4'b0010, g);
    step(4'b0010, 4'b0000, g);
    step(4'b0010, 4'b0000, g);
    refill();

    // Overflow credit on a full VC must not add a slot.
    step(4'b0000, 4'b1000, g);
    for (int n = 0; n < 6; n++) step(4'b1000, 4'b0000, g);
    refill();

    // Empty VC skipped; pointer at 1 picks VC3 before VC0.
    for (int n = 0; n < 4; n++) step(4'b0100, 4'b0000, g);
    step(4'b0001, 4'b0000, g);
    step(4'b1101, 4'b0000, g);
    step(4'b0101, 4'b0000, g);
    step(4'b0100, 4'b0000, g);

    // Reset while a flit is on the output.
    step(4'b0001, 4'b0000, g);
    do_reset();

    // Randomized traffic with occasional overflow credits.
    rq = '0;
    for (int n = 0; n < 400; n++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (!rq[v] && $urandom_range(0, 2) == 0) begin
          src_flit[v] = $urandom;
          rq[v] = 1'b1;
        end
        if (m_cnt[v] < BUF_DEPTH) cr[v] = 1'($urandom_range(0, 1));
        else                      cr[v] = ($urandom_range(0, 39) == 0);
      end
      step(rq, cr, g);
      if (g >= 0) rq[g] = 1'b0;
    end
    for (int n = 0; n < 3; n++) step('0, '0, g);
    @(negedge clock);
    check("sb_drained_end", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
